// File: rtl/ysyx_25040118_rf_wb_arbiter.sv
// Write-back arbiter and optional scoreboard in front of the register file.
// Two requesters (0: EXU, 1: LSU) share the single write port round-robin.
// The accepted write is driven to the register file one cycle after the handshake.
// Optional feature macro: YSYX_25040118_RF_SCOREBOARD_EN builds the busy-bit
// scoreboard. Without it, chk_busy is tied low and the claim inputs are ignored.
module ysyx_25040118_rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic                  claim_valid,
    input  logic [ADDR_WIDTH-1:0] claim_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    output logic                  chk_busy
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    // 0: requester 0 preferred on a tie, 1: requester 1 preferred
    logic                  prio;
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  grant_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_data_c;

    // Grant decision and selection of the winning payload
    always_comb begin
        grant0_c   = req0_valid && (!req1_valid || !prio);
        grant1_c   = req1_valid && (!req0_valid || prio);
        grant_c    = grant0_c || grant1_c;
        sel_addr_c = grant1_c ? req1_addr : req0_addr;
        sel_data_c = grant1_c ? req1_data : req0_data;
    end

    // Ready is held low while reset is asserted
    assign req0_ready = rst_n && grant0_c;
    assign req1_ready = rst_n && grant1_c;

    // Priority flips to the requester that lost; holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (grant0_c) begin
            prio <= 1'b1;
        end else if (grant1_c) begin
            prio <= 1'b0;
        end
    end

    // Registered write port; x0 writes are accepted but never issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_c && (sel_addr_c != '0)) begin
            rf_wen   <= 1'b1;
            rf_waddr <= sel_addr_c;
            rf_wdata <= sel_data_c;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef YSYX_25040118_RF_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec_c;
    logic [NUM_REGS-1:0] clr_vec_c;

    // One-hot claim and retire vectors; x0 can never be claimed
    always_comb begin
        set_vec_c = '0;
        clr_vec_c = '0;
        if (claim_valid) begin
            set_vec_c[claim_addr] = 1'b1;
        end
        if (rf_wen) begin
            clr_vec_c[rf_waddr] = 1'b1;
        end
        set_vec_c[0] = 1'b0;
    end

    // Claim wins over a retire of the same register on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec_c) | set_vec_c;
        end
    end

    assign chk_busy = busy[chk_addr];
`else
    logic unused_sb_inputs;

    // Scoreboard not built: claim/check inputs are intentionally dropped
    assign unused_sb_inputs = ^{claim_valid, claim_addr, chk_addr};
    assign chk_busy         = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25040118_rf_wb_arbiter.sv
// Self-checking bench for ysyx_25040118_rf_wb_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_ysyx_25040118_rf_wb_arbiter;

`ifdef YSYX_25040118_RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic [4:0]  chk_addr;
    logic        chk_busy;

    int errors = 0;
    int checks = 0;

    ysyx_25040118_rf_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .chk_addr    (chk_addr),
        .chk_busy    (chk_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        claim_valid = 0; claim_addr = '0; chk_addr = '0;
    endtask

    // Leaves the bench one time unit after a rising edge with reset released
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic        e_r0; logic e_r1;
        logic        e_wen; logic [4:0] e_waddr; logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[10];

    // Reference model state (randomized phase)
    bit          m_busy[32];
    bit          m_pref1;          // 1: requester 1 wins a tie
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    initial begin
        // Rows applied back-to-back right after reset; expected rf_* is the next cycle
        tbl[0] = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 5'd1, 32'h11};
        tbl[1] = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 1, 5'd2, 32'h22};
        tbl[2] = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 5'd1, 32'h11};
        tbl[3] = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 1, 5'd2, 32'h22};
        tbl[4] = '{0, 5'd0, 32'h0,  1, 5'd0, 32'h33, 0, 1, 0, 5'd2, 32'h22};
        tbl[5] = '{1, 5'd1, 32'h44, 1, 5'd2, 32'h55, 1, 0, 1, 5'd1, 32'h44};
        tbl[6] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd1, 32'h44};
        tbl[7] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd5, 32'hDEADBEEF};
        tbl[8] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd5, 32'hDEADBEEF};
        tbl[9] = '{0, 5'd0, 32'h0,  1, 5'd3, 32'h66, 0, 1, 1, 5'd3, 32'h66};

        do_reset();
        check("reset_rf_wen", 32'(rf_wen), 32'd0);
        check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);

        // ---- Directed vector table ----
        for (int i = 0; i < 10; i++) begin
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            #1;
            check($sformatf("tbl%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].e_r0));
            check($sformatf("tbl%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].e_r1));
            tick();
            idle_inputs();
            check($sformatf("tbl%0d_rf_wen", i), 32'(rf_wen), 32'(tbl[i].e_wen));
            check($sformatf("tbl%0d_rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
            check($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_wdata);
        end

        // ---- Claim 7, write 7, busy drops the cycle after rf_wen ----
        do_reset();
        claim_valid = 1; claim_addr = 5'd7; chk_addr = 5'd7;
        #1 check("claim7_before_edge", 32'(chk_busy), 32'd0);
        tick();
        claim_valid = 0;
        check("claim7_visible", 32'(chk_busy), 32'(SB));
        req0_valid = 1; req0_addr = 5'd7; req0_data = 32'hA5A5_0007;
        #1 check("wr7_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 0;
        check("wr7_rf_wen", 32'(rf_wen), 32'd1);
        check("wr7_rf_waddr", 32'(rf_waddr), 32'd7);
        check("wr7_busy_during_wen", 32'(chk_busy), 32'(SB));
        tick();
        check("wr7_rf_wen_off", 32'(rf_wen), 32'd0);
        check("wr7_busy_cleared", 32'(chk_busy), 32'd0);

        // ---- Claim during rf_wen of the same register: claim wins ----
        claim_valid = 1; claim_addr = 5'd9; chk_addr = 5'd9;
        req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h0000_0909;
        tick();
        req0_valid = 0;
        check("c9_rf_wen", 32'(rf_wen), 32'd1);
        check("c9_busy_set", 32'(chk_busy), 32'(SB));
        claim_valid = 1; claim_addr = 5'd9;
        tick();
        claim_valid = 1; claim_addr = 5'd0;
        check("c9_rf_wen_off", 32'(rf_wen), 32'd0);
        check("c9_claim_wins", 32'(chk_busy), 32'(SB));
        chk_addr = 5'd0;
        tick();
        claim_valid = 0;
        check("claim0_never_busy", 32'(chk_busy), 32'd0);
        chk_addr = 5'd9;
        #1 check("c9_still_busy", 32'(chk_busy), 32'(SB));

        // ---- Reset between handshake and its write ----
        tick();
        req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
        claim_valid = 1; claim_addr = 5'd3; chk_addr = 5'd3;
        #1 check("rst_mid_ready0", 32'(req0_ready), 32'd1);
        tick();
        rst_n = 1'b0;
        claim_valid = 0;
        #1;
        check("rst_mid_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_mid_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_mid_ready0_low", 32'(req0_ready), 32'd0);
        check("rst_mid_busy3", 32'(chk_busy), 32'd0);
        chk_addr = 5'd9;
        #1 check("rst_mid_busy9", 32'(chk_busy), 32'd0);
        tick();
        req0_valid = 0;
        rst_n = 1'b1;
        tick();
        check("rst_after_rf_wen", 32'(rf_wen), 32'd0);
        req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h2;
        #1;
        check("rst_after_ready0", 32'(req0_ready), 32'd1);
        check("rst_after_ready1", 32'(req1_ready), 32'd0);

        // ---- Randomized run against reference model ----
        do_reset();
        foreach (m_busy[k]) m_busy[k] = 0;
        m_pref1 = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        begin
            bit p0, p1, g0, g1;
            logic [4:0] a0, a1;
            logic [31:0] d0, d1;
            p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
            for (int c = 0; c < 2000; c++) begin
                // Requesters hold their payload until granted
                if (!p0 && $urandom_range(0, 2) != 0) begin
                    p0 = 1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
                end
                if (!p1 && $urandom_range(0, 2) != 0) begin
                    p1 = 1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
                end
                req0_valid = p0; req0_addr = a0; req0_data = d0;
                req1_valid = p1; req1_addr = a1; req1_data = d1;
                claim_valid = ($urandom_range(0, 2) == 0);
                claim_addr  = 5'($urandom_range(0, 7));
                chk_addr    = 5'($urandom_range(0, 7));
                #1;
                g0 = p0 && (!p1 || !m_pref1);
                g1 = p1 && (!p0 || m_pref1);
                check("rnd_ready0", 32'(req0_ready), 32'(g0));
                check("rnd_ready1", 32'(req1_ready), 32'(g1));
                check("rnd_chk_busy", 32'(chk_busy), 32'(SB && m_busy[chk_addr]));
                // Model update for the coming edge
                if (m_wen) m_busy[m_waddr] = 0;
                if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1;
                m_wen = 0;
                if (g0) begin
                    m_pref1 = 1; p0 = 0;
                    if (a0 != 0) begin m_wen = 1; m_waddr = a0; m_wdata = d0; end
                end else if (g1) begin
                    m_pref1 = 0; p1 = 0;
                    if (a1 != 0) begin m_wen = 1; m_waddr = a1; m_wdata = d1; end
                end
                tick();
                check("rnd_rf_wen", 32'(rf_wen), 32'(m_wen));
                check("rnd_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                check("rnd_rf_wdata", rf_wdata, m_wdata);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
